// File: rtl/cpu16_pkg.sv
// Shared widths and types for the 16-bit register file slice.
package cpu16_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-bit scoreboard: tracks outstanding writes and blocks dependent issue.
// Build option REGFILE_BYPASS_EN lets a same-cycle write-back hide its pending bit.
module reg_scoreboard
  import cpu16_pkg::*;
(
  input  logic                inClk,
  input  logic                inClrN,
  input  reg_addr_t           inRdAddrA,
  input  reg_addr_t           inRdAddrB,
  input  logic                inWrEn,
  input  reg_addr_t           inWrAddr,
  input  logic                inIssueEn,
  input  reg_addr_t           inIssueAddr,
  output logic                outStall,
  output logic [NUM_REGS-1:0] outPendMask
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pendNext;
  logic [NUM_REGS-1:0] effPend;

  always_comb begin
    effPend = pend;
`ifdef REGFILE_BYPASS_EN
    if (inWrEn) effPend[inWrAddr] = 1'b0;
`endif
  end

  assign outStall = inIssueEn &
                    (effPend[inRdAddrA] | effPend[inRdAddrB] | effPend[inIssueAddr]);

  // Issue is applied after the write-back clear so a new issue keeps ownership of the bit.
  always_comb begin
    pendNext = pend;
    if (inWrEn) pendNext[inWrAddr] = 1'b0;
    if (inIssueEn && !outStall) pendNext[inIssueAddr] = 1'b1;
    pendNext[0] = 1'b0;
  end

  always_ff @(posedge inClk) begin
    if (!inClrN) pend <= '0;
    else         pend <= pendNext;
  end

  assign outPendMask = pend;

endmodule

// File: rtl/reg_file16.sv
// Eight-entry 16-bit register file with two read ports, one write-back port and issue scoreboard.
// Build option REGFILE_BYPASS_EN forwards same-cycle write-back data to the read ports.
module reg_file16
  import cpu16_pkg::*;
(
  input  logic                inClk,
  input  logic                inClrN,
  input  reg_addr_t           inRdAddrA,
  input  reg_addr_t           inRdAddrB,
  output word_t               outRdDataA,
  output word_t               outRdDataB,
  input  logic                inWrEn,
  input  reg_addr_t           inWrAddr,
  input  word_t               inWrData,
  input  logic                inIssueEn,
  input  reg_addr_t           inIssueAddr,
  output logic                outStall,
  output logic [NUM_REGS-1:0] outPendMask
);

  word_t regs [NUM_REGS];
  logic  wrLive;

  assign wrLive = inWrEn && (inWrAddr != '0);

  always_ff @(posedge inClk) begin
    if (!inClrN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wrLive) begin
      regs[inWrAddr] <= inWrData;
    end
  end

  always_comb begin
    outRdDataA = (inRdAddrA == '0) ? '0 : regs[inRdAddrA];
    outRdDataB = (inRdAddrB == '0) ? '0 : regs[inRdAddrB];
`ifdef REGFILE_BYPASS_EN
    if (wrLive && (inWrAddr == inRdAddrA)) outRdDataA = inWrData;
    if (wrLive && (inWrAddr == inRdAddrB)) outRdDataB = inWrData;
`endif
  end

  reg_scoreboard uScoreboard (
    .inClk       (inClk),
    .inClrN      (inClrN),
    .inRdAddrA   (inRdAddrA),
    .inRdAddrB   (inRdAddrB),
    .inWrEn      (inWrEn),
    .inWrAddr    (inWrAddr),
    .inIssueEn   (inIssueEn),
    .inIssueAddr (inIssueAddr),
    .outStall    (outStall),
    .outPendMask (outPendMask)
  );

endmodule
